// File: rtl/tlp_tx_pkt_fifo.sv
// Store-and-forward TLP beat buffer feeding the controller TX port.
// Packets are released only once complete; malformed or overflowing packets are dropped whole.
module tlp_tx_pkt_fifo #(
   parameter int DATA_W  = 256,
   parameter int VALID_W = 8,
   parameter int AW      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_sop,
   input  logic               in_eop,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [VALID_W-1:0] in_valid,
   output logic               in_ready,
   input  logic               tx_wait,
   output logic               tx_sop,
   output logic               tx_eop,
   output logic [DATA_W-1:0]  tx_data,
   output logic [VALID_W-1:0] tx_valid,
   output logic [AW:0]        pkt_count,
   output logic               overflow,
   output logic               protocol_err
);

   localparam int          DEPTH   = 2 ** AW;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

   typedef struct packed {
      logic               sop;
      logic               eop;
      logic [VALID_W-1:0] valid;
      logic [DATA_W-1:0]  data;
   } entry_t;

   typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_e;
   typedef enum logic       {R_IDLE, R_SEND}        r_state_e;

   entry_t             mem_q [DEPTH];
   w_state_e           w_state_q;
   r_state_e           r_state_q;
   logic [AW:0]        wr_ptr_q, rd_ptr_q, pkt_start_q;
   logic [AW:0]        pkt_count_q, pkt_count_d;
   logic               pkt_inc_q;
   logic               overflow_q, protocol_err_q;
   logic               tx_sop_q, tx_eop_q;
   logic [VALID_W-1:0] tx_valid_q;
   logic [DATA_W-1:0]  tx_data_q;

   logic               beat, full, we, pkt_inc, seq_err;
   logic [AW:0]        wr_addr;
   logic               xfer, can_load, head_load, next_load, rd_load;
   entry_t             head;

   // Write-side decode; full uses registered pointers so a same-cycle read never frees a slot early.
   assign beat     = |in_valid;
   assign full     = (wr_ptr_q ^ rd_ptr_q) == PTR_MSB;
   assign we       = beat && !full && (in_sop || (w_state_q == W_PKT));
   assign wr_addr  = ((w_state_q == W_PKT) && in_sop) ? pkt_start_q : wr_ptr_q;
   assign pkt_inc  = we && in_eop;
   assign seq_err  = beat && !full &&
                     (((w_state_q == W_IDLE) && !in_sop) || ((w_state_q == W_PKT) && in_sop));

   assign xfer      = (tx_valid_q != '0) && !tx_wait;
   assign can_load  = (tx_valid_q == '0) || xfer;
   assign head_load = (r_state_q == R_IDLE) && (pkt_count_q != '0) && can_load;
   assign next_load = (r_state_q == R_SEND) && can_load;
   assign rd_load   = head_load || next_load;
   assign head      = mem_q[rd_ptr_q[AW-1:0]];

   assign pkt_count_d = pkt_count_q + {{AW{1'b0}}, pkt_inc_q} - {{AW{1'b0}}, head_load};

   // NOTE: the storage array carries no reset; pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_addr[AW-1:0]] <= {in_sop, in_eop, in_valid, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q      <= W_IDLE;
         wr_ptr_q       <= '0;
         pkt_start_q    <= '0;
         pkt_inc_q      <= 1'b0;
         overflow_q     <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         pkt_inc_q <= pkt_inc;
         if (seq_err) begin
            protocol_err_q <= 1'b1;
         end
         if (beat) begin
            if (full) begin
               overflow_q <= 1'b1;
               if (w_state_q == W_PKT) begin
                  wr_ptr_q <= pkt_start_q;
               end
               w_state_q <= in_eop ? W_IDLE : W_DROP;
            end else if (we) begin
               wr_ptr_q <= wr_addr + PTR_ONE;
               if (in_sop) begin
                  pkt_start_q <= wr_addr;
               end
               w_state_q <= in_eop ? W_IDLE : W_PKT;
            end else if (in_eop) begin
               w_state_q <= W_IDLE;
            end
         end
      end
   end

   // Single output register stage; a packet may load in the cycle its predecessor's eop leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q   <= R_IDLE;
         rd_ptr_q    <= '0;
         pkt_count_q <= '0;
         tx_sop_q    <= 1'b0;
         tx_eop_q    <= 1'b0;
         tx_valid_q  <= '0;
         tx_data_q   <= '0;
      end else begin
         pkt_count_q <= pkt_count_d;
         if (rd_load) begin
            rd_ptr_q   <= rd_ptr_q + PTR_ONE;
            tx_sop_q   <= head.sop;
            tx_eop_q   <= head.eop;
            tx_valid_q <= head.valid;
            tx_data_q  <= head.data;
            r_state_q  <= head.eop ? R_IDLE : R_SEND;
         end else if (xfer) begin
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            tx_valid_q <= '0;
         end
      end
   end

   assign in_ready     = !full;
   assign tx_sop       = tx_sop_q;
   assign tx_eop       = tx_eop_q;
   assign tx_valid     = tx_valid_q;
   assign tx_data      = tx_data_q;
   assign pkt_count    = pkt_count_q;
   assign overflow     = overflow_q;
   assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_tlp_tx_pkt_fifo.sv
// Directed bench for tlp_tx_pkt_fifo: a default-depth instance plus a depth-4 instance for overflow.
module tb_tlp_tx_pkt_fifo;

   localparam int DW = 256;
   localparam int VW = 8;
   localparam int BW = 2 + VW + DW;

   typedef struct {
      logic [BW-1:0] bt;
      int            cyc;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst, in_sop, in_eop, tx_wait;
   logic [DW-1:0] in_data;
   logic [VW-1:0] in_valid;

   logic          in_ready, tx_sop, tx_eop, overflow, protocol_err;
   logic [DW-1:0] tx_data;
   logic [VW-1:0] tx_valid;
   logic [4:0]    pkt_count;

   logic          s_in_ready, s_tx_sop, s_tx_eop, s_overflow, s_protocol_err;
   logic [DW-1:0] s_tx_data;
   logic [VW-1:0] s_tx_valid;
   logic [2:0]    s_pkt_count;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   obs_t obs[$];
   obs_t obs_s[$];

   tlp_tx_pkt_fifo #(.DATA_W(DW), .VALID_W(VW), .AW(4)) dut (
      .clk(clk), .rst(rst), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .tx_wait(tx_wait), .tx_sop(tx_sop),
      .tx_eop(tx_eop), .tx_data(tx_data), .tx_valid(tx_valid), .pkt_count(pkt_count),
      .overflow(overflow), .protocol_err(protocol_err)
   );

   tlp_tx_pkt_fifo #(.DATA_W(DW), .VALID_W(VW), .AW(2)) dut_s (
      .clk(clk), .rst(rst), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
      .in_valid(in_valid), .in_ready(s_in_ready), .tx_wait(tx_wait), .tx_sop(s_tx_sop),
      .tx_eop(s_tx_eop), .tx_data(s_tx_data), .tx_valid(s_tx_valid), .pkt_count(s_pkt_count),
      .overflow(s_overflow), .protocol_err(s_protocol_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record each beat that the controller will accept at the coming rising edge.
   always @(negedge clk) begin
      obs_t o;
      if (!rst && !tx_wait) begin
         if (tx_valid != '0) begin
            o.bt  = {tx_sop, tx_eop, tx_valid, tx_data};
            o.cyc = cyc;
            obs.push_back(o);
         end
         if (s_tx_valid != '0) begin
            o.bt  = {s_tx_sop, s_tx_eop, s_tx_valid, s_tx_data};
            o.cyc = cyc;
            obs_s.push_back(o);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sop, input logic eop, input logic [VW-1:0] v,
                        input logic [DW-1:0] d);
      in_sop   = sop;
      in_eop   = eop;
      in_valid = v;
      in_data  = d;
   endtask

   task automatic idle_in();
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_valid = '0;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      tx_wait = 1'b0;
      idle_in();
      tick();
      tick();
      rst = 1'b0;
      obs.delete();
      obs_s.delete();
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      tx_wait = 1'b0;
      in_data = '0;
      idle_in();
      tick();
      tick();
      checks++;
      if ({tx_sop, tx_eop, tx_valid, tx_data} !== {BW{1'b0}}) begin
         errors++;
         $display("FAIL reset_tx: got %h expected 0", {tx_sop, tx_eop, tx_valid, tx_data});
      end
      checks++;
      if ({pkt_count, overflow, protocol_err, in_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_status: got pc=%0d ovf=%b perr=%b rdy=%b expected 0 0 0 1",
                  pkt_count, overflow, protocol_err, in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_beat();
      logic [DW-1:0] da;
      da = {32{8'hA5}};
      do_reset();
      drive(1'b1, 1'b1, 8'h0F, da);
      tick();
      idle_in();
      checks++;
      if ({pkt_count, tx_valid} !== {5'd0, 8'h00}) begin
         errors++;
         $display("FAIL single_n0: got pc=%0d valid=%h expected 0 00", pkt_count, tx_valid);
      end
      tick();
      checks++;
      if ({pkt_count, tx_valid} !== {5'd1, 8'h00}) begin
         errors++;
         $display("FAIL single_n1: got pc=%0d valid=%h expected 1 00", pkt_count, tx_valid);
      end
      tick();
      checks++;
      if ({tx_sop, tx_eop, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h0F, da}) begin
         errors++;
         $display("FAIL single_beat: got %h expected %h",
                  {tx_sop, tx_eop, tx_valid, tx_data}, {1'b1, 1'b1, 8'h0F, da});
      end
      checks++;
      if (pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL single_pc_after_load: got %0d expected 0", pkt_count);
      end
      tick();
      checks++;
      if (tx_valid !== 8'h00) begin
         errors++;
         $display("FAIL single_drain: got valid=%h expected 00", tx_valid);
      end
      repeat (4) tick();
      checks++;
      if (obs.size() !== 1) begin
         errors++;
         $display("FAIL single_count: got %0d beats expected 1", obs.size());
      end
   endtask

   task automatic test_wait_hold();
      logic [DW-1:0] d [3];
      logic [BW-1:0] exp_b [3];
      d[0] = {8{32'hD000_0000}};
      d[1] = {8{32'hD111_1111}};
      d[2] = {8{32'hD222_2222}};
      exp_b[0] = {1'b1, 1'b0, 8'hFF, d[0]};
      exp_b[1] = {1'b0, 1'b0, 8'hFF, d[1]};
      exp_b[2] = {1'b0, 1'b1, 8'h03, d[2]};
      do_reset();
      tx_wait = 1'b1;
      drive(1'b1, 1'b0, 8'hFF, d[0]);
      tick();
      drive(1'b0, 1'b0, 8'hFF, d[1]);
      tick();
      drive(1'b0, 1'b1, 8'h03, d[2]);
      tick();
      idle_in();
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({tx_sop, tx_eop, tx_valid, tx_data} !== exp_b[0]) begin
            errors++;
            $display("FAIL wait_hold_%0d: got %h expected %h", k,
                     {tx_sop, tx_eop, tx_valid, tx_data}, exp_b[0]);
         end
         tick();
      end
      tx_wait = 1'b0;
      repeat (6) tick();
      checks++;
      if (obs.size() !== 3) begin
         errors++;
         $display("FAIL wait_count: got %0d beats expected 3", obs.size());
      end
      for (int i = 0; i < obs.size() && i < 3; i++) begin
         checks++;
         if (obs[i].bt !== exp_b[i] || obs[i].cyc !== obs[0].cyc + i) begin
            errors++;
            $display("FAIL wait_beat_%0d: got %h at +%0d expected %h at +%0d", i,
                     obs[i].bt, obs[i].cyc - obs[0].cyc, exp_b[i], i);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] exp_b [4];
      exp_b[0] = {1'b1, 1'b0, 8'hFF, {8{32'hAAAA_0000}}};
      exp_b[1] = {1'b0, 1'b1, 8'h0F, {8{32'hAAAA_0001}}};
      exp_b[2] = {1'b1, 1'b0, 8'hFF, {8{32'hBBBB_0000}}};
      exp_b[3] = {1'b0, 1'b1, 8'h01, {8{32'hBBBB_0001}}};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(exp_b[i][BW-1], exp_b[i][BW-2], exp_b[i][DW +: VW], exp_b[i][DW-1:0]);
         tick();
      end
      idle_in();
      repeat (8) tick();
      checks++;
      if (obs.size() !== 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d beats expected 4", obs.size());
      end
      for (int i = 0; i < obs.size() && i < 4; i++) begin
         checks++;
         if (obs[i].bt !== exp_b[i] || obs[i].cyc !== obs[0].cyc + i) begin
            errors++;
            $display("FAIL b2b_beat_%0d: got %h at +%0d expected %h at +%0d", i,
                     obs[i].bt, obs[i].cyc - obs[0].cyc, exp_b[i], i);
         end
      end
      checks++;
      if (pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL b2b_pc_end: got %0d expected 0", pkt_count);
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] dq;
      dq = {8{32'h5151_5151}};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(i == 0, i == 4, 8'hFF, {8{32'hC000_0000 + i}});
         tick();
         if (i == 3) begin
            checks++;
            if (s_in_ready !== 1'b0) begin
               errors++;
               $display("FAIL ovf_full: got in_ready=%b expected 0", s_in_ready);
            end
         end
      end
      idle_in();
      checks++;
      if ({s_overflow, s_in_ready, s_pkt_count} !== {1'b1, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL ovf_flag: got ovf=%b rdy=%b pc=%0d expected 1 1 0",
                  s_overflow, s_in_ready, s_pkt_count);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_deep: got %b expected 0", overflow);
      end
      drive(1'b1, 1'b1, 8'h0F, dq);
      tick();
      idle_in();
      repeat (6) tick();
      checks++;
      if (obs_s.size() !== 1) begin
         errors++;
         $display("FAIL ovf_count: got %0d beats expected 1", obs_s.size());
      end
      if (obs_s.size() > 0) begin
         checks++;
         if (obs_s[0].bt !== {1'b1, 1'b1, 8'h0F, dq}) begin
            errors++;
            $display("FAIL ovf_next_pkt: got %h expected %h", obs_s[0].bt,
                     {1'b1, 1'b1, 8'h0F, dq});
         end
      end
      checks++;
      if (s_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got %b expected 1", s_overflow);
      end
   endtask

   task automatic test_protocol_err();
      logic [BW-1:0] exp_b [2];
      logic [DW-1:0] dw;
      exp_b[0] = {1'b1, 1'b0, 8'hFF, {8{32'hEEEE_0002}}};
      exp_b[1] = {1'b0, 1'b1, 8'h0F, {8{32'hEEEE_0003}}};
      dw = {8{32'h7777_7777}};
      do_reset();
      drive(1'b1, 1'b0, 8'hFF, {8{32'hEEEE_0000}});
      tick();
      drive(1'b0, 1'b0, 8'hFF, {8{32'hEEEE_0001}});
      tick();
      drive(1'b1, 1'b0, 8'hFF, {8{32'hEEEE_0002}});
      tick();
      drive(1'b0, 1'b1, 8'h0F, {8{32'hEEEE_0003}});
      tick();
      idle_in();
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++;
         $display("FAIL perr_midsop: got %b expected 1", protocol_err);
      end
      repeat (8) tick();
      checks++;
      if (obs.size() !== 2) begin
         errors++;
         $display("FAIL perr_count: got %0d beats expected 2", obs.size());
      end
      for (int i = 0; i < obs.size() && i < 2; i++) begin
         checks++;
         if (obs[i].bt !== exp_b[i]) begin
            errors++;
            $display("FAIL perr_beat_%0d: got %h expected %h", i, obs[i].bt, exp_b[i]);
         end
      end

      do_reset();
      drive(1'b0, 1'b1, 8'hFF, {8{32'h9999_9999}});
      tick();
      idle_in();
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++;
         $display("FAIL perr_nosop: got %b expected 1", protocol_err);
      end
      repeat (6) tick();
      checks++;
      if (obs.size() !== 0 || pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL perr_nostore: got %0d beats pc=%0d expected 0 0", obs.size(), pkt_count);
      end
      drive(1'b1, 1'b1, 8'h0F, dw);
      tick();
      idle_in();
      repeat (6) tick();
      checks++;
      if (obs.size() !== 1) begin
         errors++;
         $display("FAIL perr_after_count: got %0d beats expected 1", obs.size());
      end
      if (obs.size() > 0) begin
         checks++;
         if (obs[0].bt !== {1'b1, 1'b1, 8'h0F, dw}) begin
            errors++;
            $display("FAIL perr_after_beat: got %h expected %h", obs[0].bt,
                     {1'b1, 1'b1, 8'h0F, dw});
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b0, 1'b0, 8'hFF, {8{32'h1234_5678}});
      tick();
      drive(1'b1, 1'b0, 8'hFF, {8{32'hF000_0000}});
      tick();
      drive(1'b0, 1'b0, 8'hFF, {8{32'hF000_0001}});
      tick();
      drive(1'b0, 1'b1, 8'hFF, {8{32'hF000_0002}});
      tick();
      drive(1'b1, 1'b0, 8'hFF, {8{32'hF111_0000}});
      tick();
      drive(1'b0, 1'b0, 8'hFF, {8{32'hF111_0001}});
      tick();
      idle_in();
      tick();
      checks++;
      if ({tx_sop, tx_valid, tx_data, protocol_err} !==
          {1'b0, 8'hFF, {8{32'hF000_0001}}, 1'b1}) begin
         errors++;
         $display("FAIL rstmid_pre: got sop=%b valid=%h perr=%b expected 0 ff 1",
                  tx_sop, tx_valid, protocol_err);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({tx_sop, tx_eop, tx_valid, pkt_count, overflow, protocol_err} !== {17{1'b0}}) begin
         errors++;
         $display("FAIL rstmid_clear: got sop=%b eop=%b valid=%h pc=%0d ovf=%b perr=%b expected all 0",
                  tx_sop, tx_eop, tx_valid, pkt_count, overflow, protocol_err);
      end
      rst = 1'b0;
      obs.delete();
      repeat (12) tick();
      checks++;
      if (obs.size() !== 0) begin
         errors++;
         $display("FAIL rstmid_quiet: got %0d beats expected 0", obs.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_wait_hold();
      test_back_to_back();
      test_overflow();
      test_protocol_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
